ahb_sram_wbuf_slave: RTL and testbench

- AHB-Lite slave that bridges one bus slave port to a single-port synchronous SRAM (1-cycle read latency), using a one-entry posted write buffer.
- Drives one HSEL/HREADYOUT/HRESP/HRDATA port of the AHB slave multiplexer; receives that mux's HREADY as its bus-ready input.
- Zero-wait reads and writes in the common case, read-after-write byte merge, and a two-cycle ERROR response for illegal transfer sizes or alignments.

---
 rtl/ahb_sram_wbuf_slave.sv | 81 ++++++++
 tb/tb_ahb_sram_wbuf_slave.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ahb_sram_wbuf_slave.sv
// ahb_sram_wbuf_slave: AHB-Lite to single-port SRAM bridge with a one-entry posted write buffer
module ahb_sram_wbuf_slave #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic          HREADY,
  input  logic [DW-1:0] HWDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [DW-1:0] HRDATA,
  input  logic [DW-1:0] SRAMRDATA,
  output logic [AW-3:0] SRAMADDR,
  output logic [3:0]    SRAMWEN,
  output logic [DW-1:0] SRAMWDATA,
  output logic          SRAMCS
);
  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;
  state_t r_state, w_next;
  logic          r_wr_pend, r_buf_valid, r_rd_dp;
  logic [AW-3:0] r_ap_addr, r_buf_addr;
  logic [3:0]    r_ap_mask, r_buf_mask;
  logic [DW-1:0] r_buf_data, w_lane;
  logic          w_acc, w_legal, w_rd_issue, w_wr_acc, w_drain, w_load, w_stall;
  logic [3:0]    w_mask;
  always_comb begin
    w_acc      = HSEL & HREADY & HTRANS[1];
    w_legal    = (HSIZE == 3'd0) | ((HSIZE == 3'd1) & ~HADDR[0]) | ((HSIZE == 3'd2) & (HADDR[1:0] == 2'b00));
    w_mask     = (HSIZE == 3'd0) ? 4'b0001 << HADDR[1:0] : (HSIZE == 3'd1) ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w_rd_issue = w_acc & ~HWRITE & w_legal & ~HRESET;
    w_wr_acc   = w_acc & HWRITE & w_legal;
    // gating with reset keeps a buffered write from reaching the SRAM during reset
    w_drain    = r_buf_valid & ~w_rd_issue & ~HRESET;
    w_load     = r_wr_pend & HREADY;
    w_stall    = r_wr_pend & r_buf_valid & HSEL & HTRANS[1] & ~HWRITE;
    w_lane     = {{8{r_buf_mask[3]}}, {8{r_buf_mask[2]}}, {8{r_buf_mask[1]}}, {8{r_buf_mask[0]}}}
               & {DW{r_buf_valid && (r_buf_addr == r_ap_addr)}};
    HRDATA     = r_rd_dp ? (SRAMRDATA & ~w_lane) | (r_buf_data & w_lane) : '0;
    SRAMCS     = w_rd_issue | w_drain;
    SRAMWEN    = w_drain ? r_buf_mask : 4'b0000;
    SRAMADDR   = w_rd_issue ? HADDR[AW-1:2] : w_drain ? r_buf_addr : '0;
    SRAMWDATA  = w_drain ? r_buf_data : '0;
  end
  always_comb begin
    w_next    = (r_state == ERR1) ? ERR2 : (w_acc & ~w_legal) ? ERR1 : IDLE;
    HREADYOUT = (r_state != ERR1) & ~w_stall;
    HRESP     = r_state != IDLE;
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= IDLE;
      r_wr_pend   <= 1'b0;
      r_buf_valid <= 1'b0;
      r_rd_dp     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_buf_valid <= w_load | (r_buf_valid & ~w_drain);
      if (HREADY) begin
        r_wr_pend <= w_wr_acc;
        r_rd_dp   <= w_rd_issue;
      end
    end
  end
  always_ff @(posedge HCLK) begin
    if (HREADY) begin
      r_ap_addr <= HADDR[AW-1:2];
      r_ap_mask <= w_mask;
    end
    if (w_load) begin
      r_buf_addr <= r_ap_addr;
      r_buf_mask <= r_ap_mask;
      r_buf_data <= HWDATA;
    end
  end
endmodule

// File: tb/tb_ahb_sram_wbuf_slave.sv
// tb_ahb_sram_wbuf_slave: directed bench with a behavioural SRAM and single-slave HREADY loopback
module tb_ahb_sram_wbuf_slave;
  logic        HCLK = 1'b0, HRESET;
  logic        HSEL, HWRITE;
  logic [15:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA, HRDATA, SRAMRDATA, SRAMWDATA;
  logic        HREADYOUT, HRESP, SRAMCS;
  logic [13:0] SRAMADDR;
  logic [3:0]  SRAMWEN;
  logic [31:0] mem [0:16383];
  int n_chk = 0, n_fail = 0;

  always #5 HCLK = ~HCLK;

  ahb_sram_wbuf_slave #(.AW(16), .DW(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADYOUT), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .SRAMRDATA(SRAMRDATA),
    .SRAMADDR(SRAMADDR), .SRAMWEN(SRAMWEN), .SRAMWDATA(SRAMWDATA), .SRAMCS(SRAMCS)
  );

  always @(posedge HCLK) begin
    if (SRAMCS) begin
      if (SRAMWEN == 4'b0000) SRAMRDATA <= mem[SRAMADDR];
      for (int b = 0; b < 4; b++)
        if (SRAMWEN[b]) mem[SRAMADDR][8*b +: 8] <= SRAMWDATA[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ap(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz, input logic [15:0] a);
    HSEL = sel; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = a;
  endtask

  task automatic idle();
    ap(1'b0, 2'b00, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic nxt();
    @(posedge HCLK); #1;
  endtask

  task automatic bus(input string tag, input logic rdy, input logic resp);
    chk(tag, {30'b0, HREADYOUT, HRESP}, {30'b0, rdy, resp});
  endtask

  task automatic sram(input string tag, input logic cs, input logic [3:0] wen, input logic [13:0] a);
    chk(tag, {13'b0, SRAMCS, SRAMWEN, SRAMADDR}, {13'b0, cs, wen, a});
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    SRAMRDATA = 32'h0;
    HWDATA = 32'h0;
    HRESET = 1'b1;
    idle();
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    bus("rst_bus", 1'b1, 1'b0);
    chk("rst_hrdata", HRDATA, 32'h0);
    sram("rst_sram", 1'b0, 4'h0, 14'h0);
    chk("rst_wdata", SRAMWDATA, 32'h0);
    nxt();
    // word write then read back
    ap(1'b1, 2'b10, 1'b1, 3'd2, 16'h0010);
    @(negedge HCLK); bus("w1_ap", 1'b1, 1'b0); sram("w1_ap_sram", 1'b0, 4'h0, 14'h0);
    nxt(); idle(); HWDATA = 32'hDEADBEEF;
    @(negedge HCLK); bus("w1_dp", 1'b1, 1'b0); sram("w1_dp_sram", 1'b0, 4'h0, 14'h0);
    nxt();
    @(negedge HCLK); sram("w1_drain", 1'b1, 4'hF, 14'h0004); chk("w1_drain_data", SRAMWDATA, 32'hDEADBEEF);
    nxt();
    @(negedge HCLK); sram("w1_done", 1'b0, 4'h0, 14'h0); chk("w1_mem", mem[4], 32'hDEADBEEF);
    nxt(); ap(1'b1, 2'b10, 1'b0, 3'd2, 16'h0010);
    @(negedge HCLK); bus("r1_ap", 1'b1, 1'b0); sram("r1_issue", 1'b1, 4'h0, 14'h0004);
    nxt(); idle();
    @(negedge HCLK); bus("r1_dp", 1'b1, 1'b0); chk("r1_data", HRDATA, 32'hDEADBEEF);
    nxt();
    @(negedge HCLK); chk("r1_idle_hrdata", HRDATA, 32'h0);
    // byte write followed by word read of the same word: lane merge
    mem[8] = 32'h11223344;
    nxt(); ap(1'b1, 2'b10, 1'b1, 3'd0, 16'h0021);
    nxt(); ap(1'b1, 2'b10, 1'b0, 3'd2, 16'h0020); HWDATA = 32'h0000AA00;
    @(negedge HCLK); bus("m_rd_ap", 1'b1, 1'b0); sram("m_issue", 1'b1, 4'h0, 14'h0008);
    nxt(); idle();
    @(negedge HCLK); bus("m_dp", 1'b1, 1'b0); chk("m_data", HRDATA, 32'h1122AA44);
    sram("m_drain", 1'b1, 4'h2, 14'h0008); chk("m_drain_data", SRAMWDATA, 32'h0000AA00);
    nxt();
    @(negedge HCLK); chk("m_mem", mem[8], 32'h1122AA44);
    // W, W, R back to back: one stall cycle in the second write's data phase
    mem[2] = 32'h00000033;
    nxt(); ap(1'b1, 2'b10, 1'b1, 3'd2, 16'h0000);
    @(negedge HCLK); bus("b_w0_ap", 1'b1, 1'b0);
    nxt(); ap(1'b1, 2'b10, 1'b1, 3'd2, 16'h0004); HWDATA = 32'h1;
    @(negedge HCLK); bus("b_w1_ap", 1'b1, 1'b0); sram("b_w1_ap_sram", 1'b0, 4'h0, 14'h0);
    nxt(); ap(1'b1, 2'b10, 1'b0, 3'd2, 16'h0008); HWDATA = 32'h2;
    @(negedge HCLK); bus("b_stall", 1'b0, 1'b0); sram("b_drain0", 1'b1, 4'hF, 14'h0000); chk("b_drain0_data", SRAMWDATA, 32'h1);
    nxt();
    @(negedge HCLK); bus("b_unstall", 1'b1, 1'b0); sram("b_rd_issue", 1'b1, 4'h0, 14'h0002);
    nxt(); idle();
    @(negedge HCLK); bus("b_rd_dp", 1'b1, 1'b0); chk("b_rd_data", HRDATA, 32'h33);
    sram("b_drain1", 1'b1, 4'hF, 14'h0001); chk("b_drain1_data", SRAMWDATA, 32'h2);
    nxt();
    @(negedge HCLK); chk("b_mem0", mem[0], 32'h1); chk("b_mem1", mem[1], 32'h2);
    // misaligned halfword write: two-cycle error, no SRAM access, then a legal read
    nxt(); ap(1'b1, 2'b10, 1'b1, 3'd1, 16'h0003);
    @(negedge HCLK); bus("e_ap", 1'b1, 1'b0); sram("e_ap_sram", 1'b0, 4'h0, 14'h0);
    nxt(); idle(); HWDATA = 32'hFFFFFFFF;
    @(negedge HCLK); bus("e_err1", 1'b0, 1'b1); sram("e_err1_sram", 1'b0, 4'h0, 14'h0);
    nxt(); ap(1'b1, 2'b10, 1'b0, 3'd2, 16'h0020);
    @(negedge HCLK); bus("e_err2", 1'b1, 1'b1); sram("e_rd_issue", 1'b1, 4'h0, 14'h0008);
    nxt(); idle();
    @(negedge HCLK); bus("e_rd_dp", 1'b1, 1'b0); chk("e_rd_data", HRDATA, 32'h1122AA44); sram("e_no_drain", 1'b0, 4'h0, 14'h0);
    // HSIZE=3 read, then an illegal write in ERR2
    nxt(); ap(1'b1, 2'b10, 1'b0, 3'd3, 16'h0000);
    @(negedge HCLK); bus("x_ap", 1'b1, 1'b0); sram("x_ap_sram", 1'b0, 4'h0, 14'h0);
    nxt(); idle();
    @(negedge HCLK); bus("x_err1a", 1'b0, 1'b1);
    nxt(); ap(1'b1, 2'b10, 1'b1, 3'd2, 16'h0002);
    @(negedge HCLK); bus("x_err2a", 1'b1, 1'b1); sram("x_err2a_sram", 1'b0, 4'h0, 14'h0);
    nxt(); idle();
    @(negedge HCLK); bus("x_err1b", 1'b0, 1'b1); sram("x_err1b_sram", 1'b0, 4'h0, 14'h0);
    nxt();
    @(negedge HCLK); bus("x_err2b", 1'b1, 1'b1);
    nxt();
    @(negedge HCLK); bus("x_idle", 1'b1, 1'b0);
    // reset with a buffered write pending: write is discarded
    mem[12] = 32'h00000055;
    nxt(); ap(1'b1, 2'b10, 1'b1, 3'd2, 16'h0030);
    nxt(); idle(); HWDATA = 32'h00000099;
    nxt(); HRESET = 1'b1;
    @(negedge HCLK); sram("r_no_write", 1'b0, 4'h0, 14'h0);
    nxt(); HRESET = 1'b0;
    @(negedge HCLK); bus("r_bus", 1'b1, 1'b0); chk("r_hrdata", HRDATA, 32'h0);
    sram("r_sram", 1'b0, 4'h0, 14'h0); chk("r_wdata", SRAMWDATA, 32'h0);
    nxt(); ap(1'b1, 2'b10, 1'b0, 3'd2, 16'h0030);
    nxt(); idle();
    @(negedge HCLK); chk("r_old_data", HRDATA, 32'h55); chk("r_mem", mem[12], 32'h55);
    nxt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
